// File: rtl/operand_input_pkg.sv
// Shared calculator definitions: FSM state encoding, timing defaults, counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a (no datapath).
package operand_input_pkg;

  // 20 ms debounce and 4 ms hold at a 50 MHz system clock.
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int HOLD_CYCLES_DEF     = 200000;

  // Button FSM state encodings.
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_DB_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_DB_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    DB_PRESS   = ST_DB_PRESS,
    HELD       = ST_HELD,
    DB_RELEASE = ST_DB_RELEASE
  } btn_state_t;

  // One counter serves both debounce and hold timing, so it is sized for the larger
  // of the two, with one spare bit so the hold count can saturate at HOLD_CYCLES.
  function automatic int cnt_width(input int db_cycles, input int hold_cycles);
    int biggest;
    biggest = (db_cycles > hold_cycles) ? db_cycles : hold_cycles;
    return $clog2(biggest) + 1;
  endfunction

endpackage

// File: rtl/operand_input_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, WIDTH bits wide.
// Latency: 2 Clk cycles from input to q.
// Backpressure: none; samples every cycle.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; the second gives it a full cycle to resolve.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/operand_input.sv
// Debounces the add button, captures the operand switches and stretches the add level.
// Latency: 2-cycle sync plus DEBOUNCE_CYCLES+1 stable samples to add_pulse/add_out.
// Backpressure: none; add_out held >= HOLD_CYCLES so a slow downstream strobe sees it.
module operand_input
  import operand_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       add_btn,
  input  logic [3:0] data_sw,
  output logic       add_out,
  output logic [3:0] operand,
  output logic       add_pulse,
  output logic [7:0] press_count
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_SAT  = CW'(HOLD_CYCLES);

  logic       btn_s;
  logic [3:0] sw_s;

  btn_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          add_out_nxt;

  sync2 #(.WIDTH(1)) u_sync_btn (
    .Clk   (Clk),
    .reset (reset),
    .d     (add_btn),
    .q     (btn_s)
  );

  sync2 #(.WIDTH(4)) u_sync_sw (
    .Clk   (Clk),
    .reset (reset),
    .d     (data_sw),
    .q     (sw_s)
  );

  // State and shared counter registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter logic; accept marks the single qualified-press cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = DB_PRESS;
          cnt_nxt   = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          // Bounce: drop back without counting a press.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD: begin
        // Release is only considered once the minimum hold time has elapsed.
        if (!btn_s && (cnt >= HOLD_LAST)) begin
          state_nxt = DB_RELEASE;
          cnt_nxt   = '0;
        end else if (cnt < HOLD_SAT) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DB_RELEASE: begin
        if (btn_s) begin
          // Release bounce: hold time already served, so keep cnt saturated.
          state_nxt = HELD;
          cnt_nxt   = HOLD_SAT;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // add_out decoded from next state so the registered level tracks state exactly.
  always_comb begin
    add_out_nxt = (state_nxt == HELD) || (state_nxt == DB_RELEASE);
  end

  // Registered, glitch-free output level and one-cycle press strobe.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      add_out   <= 1'b0;
      add_pulse <= 1'b0;
    end else begin
      add_out   <= add_out_nxt;
      add_pulse <= accept;
    end
  end

  // Operand capture and press counter move only on an accepted press; counter wraps.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      operand     <= 4'h0;
      press_count <= 8'h00;
    end else if (accept) begin
      operand     <= sw_s;
      press_count <= press_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_operand_input.sv
// Self-checking bench for operand_input with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_operand_input;

  localparam int DB   = 4;
  localparam int HOLD = 8;

  logic       Clk;
  logic       reset;
  logic       add_btn;
  logic [3:0] data_sw;
  logic       add_out;
  logic [3:0] operand;
  logic       add_pulse;
  logic [7:0] press_count;

  operand_input #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .add_btn     (add_btn),
    .data_sw     (data_sw),
    .add_out     (add_out),
    .operand     (operand),
    .add_pulse   (add_pulse),
    .press_count (press_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses_seen;
  int high_cycles;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a press is accepted after DB+1 consecutive high synchronized
  // samples while inactive; the add level ends on the edge completing DB+1
  // consecutive low samples, all taken no earlier than HOLD edges after acceptance.
  int         m_edge, m_acc_edge, m_hi_run, m_lo_run;
  logic       m_b1, m_b2;
  logic [3:0] m_d1, m_d2;
  logic       m_active, m_pulse;
  logic [3:0] m_operand;
  logic [7:0] m_count;

  task automatic model_reset();
    m_edge = 0; m_acc_edge = 0; m_hi_run = 0; m_lo_run = 0;
    m_b1 = 1'b0; m_b2 = 1'b0; m_d1 = 4'h0; m_d2 = 4'h0;
    m_active = 1'b0; m_pulse = 1'b0; m_operand = 4'h0; m_count = 8'h00;
  endtask

  task automatic model_edge(input logic b, input logic [3:0] d);
    logic       bs;
    logic [3:0] ds;
    int         elig;
    bs = m_b2;  ds = m_d2;
    m_b2 = m_b1; m_b1 = b;
    m_d2 = m_d1; m_d1 = d;
    m_edge++;
    if (bs) begin m_hi_run++; m_lo_run = 0; end
    else    begin m_lo_run++; m_hi_run = 0; end
    m_pulse = 1'b0;
    if (!m_active) begin
      if (m_hi_run >= DB + 1) begin
        m_active   = 1'b1;
        m_acc_edge = m_edge;
        m_pulse    = 1'b1;
        m_operand  = ds;
        m_count    = m_count + 8'd1;
      end
    end else begin
      elig = m_edge - (m_acc_edge + HOLD) + 1;
      if (elig > m_lo_run) elig = m_lo_run;
      if (elig >= DB + 1) m_active = 1'b0;
    end
  endtask

  // One clock cycle: drive, advance model at the edge, compare 2 time units later.
  task automatic tick(input logic b, input logic [3:0] sw);
    add_btn = b;
    data_sw = sw;
    @(posedge Clk);
    if (reset) model_edge(b, sw);
    else       model_reset();
    #2;
    if (add_pulse) pulses_seen++;
    if (add_out)   high_cycles++;
    check("add_out",     add_out,     m_active);
    check("add_pulse",   add_pulse,   m_pulse);
    check("operand",     operand,     m_operand);
    check("press_count", press_count, m_count);
  endtask

  // Asynchronous reset pulse applied between edges; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_add_out",     add_out,     0);
    check("rst_add_pulse",   add_pulse,   0);
    check("rst_operand",     operand,     0);
    check("rst_press_count", press_count, 0);
    tick(add_btn, data_sw);
    tick(add_btn, data_sw);
    #2;
    reset = 1'b1;
  endtask

  typedef struct {
    int         len;
    logic [3:0] sw;
    int         exp_pulses;
    int         exp_high;
    logic [3:0] exp_operand;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int first_pulse;
    logic lvl;
    vecs[0] = '{len: 20, sw: 4'h5, exp_pulses: 1, exp_high: 20, exp_operand: 4'h5, exp_count: 8'd1};
    vecs[1] = '{len: 5,  sw: 4'hC, exp_pulses: 1, exp_high: 12, exp_operand: 4'hC, exp_count: 8'd2};
    vecs[2] = '{len: 4,  sw: 4'h9, exp_pulses: 0, exp_high: 0,  exp_operand: 4'hC, exp_count: 8'd2};
    vecs[3] = '{len: 1,  sw: 4'h7, exp_pulses: 0, exp_high: 0,  exp_operand: 4'hC, exp_count: 8'd2};
    vecs[4] = '{len: 8,  sw: 4'hE, exp_pulses: 1, exp_high: 12, exp_operand: 4'hE, exp_count: 8'd3};
    vecs[5] = '{len: 13, sw: 4'h1, exp_pulses: 1, exp_high: 13, exp_operand: 4'h1, exp_count: 8'd4};
    vecs[6] = '{len: 12, sw: 4'h6, exp_pulses: 1, exp_high: 12, exp_operand: 4'h6, exp_count: 8'd5};

    add_btn = 1'b0;
    data_sw = 4'h0;
    reset   = 1'b1;
    #1;
    do_reset();

    // Bouncing button never qualifies.
    pulses_seen = 0; high_cycles = 0;
    foreach (vecs[0].sw[i]) tick(1'b0, 4'h0);
    for (int i = 0; i < 8; i++) tick(((i / 2) % 2) == 0, 4'hB);
    for (int i = 0; i < 20; i++) tick(1'b0, 4'hB);
    check("bounce_pulses", pulses_seen, 0);
    check("bounce_high",   high_cycles, 0);
    check("bounce_count",  press_count, 0);

    // Table of clean presses of various lengths.
    for (int v = 0; v < 7; v++) begin
      pulses_seen = 0; high_cycles = 0;
      for (int i = 0; i < vecs[v].len; i++) tick(1'b1, vecs[v].sw);
      for (int i = 0; i < 30; i++) tick(1'b0, vecs[v].sw);
      check($sformatf("vec%0d_pulses", v),  pulses_seen, vecs[v].exp_pulses);
      check($sformatf("vec%0d_high", v),    high_cycles, vecs[v].exp_high);
      check($sformatf("vec%0d_operand", v), operand,     vecs[v].exp_operand);
      check($sformatf("vec%0d_count", v),   press_count, vecs[v].exp_count);
    end

    // Switches change while add_out is high: operand holds until the next press.
    for (int i = 0; i < 6; i++) tick(1'b1, 4'h3);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 4'hA);
      check("sw_change_operand", operand, 4'h3);
    end
    for (int i = 0; i < 6; i++) tick(1'b1, 4'hA);
    for (int i = 0; i < 20; i++) tick(1'b0, 4'hA);
    check("next_press_operand", operand, 4'hA);

    // Reset in the middle of HELD with the button still held afterwards.
    for (int i = 0; i < 8; i++) tick(1'b1, 4'h9);
    check("midheld_add_out", add_out, 1);
    do_reset();
    first_pulse = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 4'h9);
      if (add_pulse && first_pulse == 0) first_pulse = i;
    end
    check("post_reset_first_pulse", first_pulse, 7);
    for (int i = 0; i < 30; i++) tick(1'b0, 4'h9);

    // Randomized bursts against the model.
    lvl = 1'b0;
    for (int b = 0; b < 80; b++) begin
      int run;
      run = $urandom_range(1, 14);
      lvl = ~lvl;
      for (int i = 0; i < run; i++) tick(lvl, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 30; i++) tick(1'b0, 4'h0);

    // 256 accepted presses: counter wraps to zero.
    do_reset();
    pulses_seen = 0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 6; i++) tick(1'b1, 4'(p));
      for (int i = 0; i < 20; i++) tick(1'b0, 4'(p));
      if (p == 254) check("count_at_255", press_count, 255);
    end
    check("wrap_count",  press_count, 0);
    check("wrap_pulses", pulses_seen, 256);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
